// File: rtl/s3_inc8_unit.sv
// s3_inc8_unit: 8-bit incrementer (x = a + 1 mod 256) with carry-out and registered copies.
// Optional macro S3_INC8_CHECK_EN adds a sticky self-check flag on err; otherwise err is tied low.
module s3_inc8_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  output logic [7:0] x,
  output logic       co,
  output logic [7:0] x_q,
  output logic       co_q,
  output logic       err
);

  logic       w_lp1;
  logic       w_lp2;
  logic       w_lp3;
  logic       w_p0;
  logic       w_hp5;
  logic       w_hp6;
  logic       w_hp7;
  logic       w_gh;
  logic [7:0] w_x;
  logic       w_co;
  logic [7:0] r_x;
  logic       r_co;

  // Two 4-bit lookahead groups; the high group never waits on a chain longer than four ANDs.
  assign w_lp1 = a[0];
  assign w_lp2 = a[0] & a[1];
  assign w_lp3 = a[0] & a[1] & a[2];
  assign w_p0  = &a[3:0];

  assign w_hp5 = a[4];
  assign w_hp6 = a[4] & a[5];
  assign w_hp7 = a[4] & a[5] & a[6];
  assign w_gh  = &a[7:4];

  assign w_x[0] = ~a[0];
  assign w_x[1] = a[1] ^ w_lp1;
  assign w_x[2] = a[2] ^ w_lp2;
  assign w_x[3] = a[3] ^ w_lp3;
  assign w_x[4] = a[4] ^ w_p0;
  assign w_x[5] = a[5] ^ (w_p0 & w_hp5);
  assign w_x[6] = a[6] ^ (w_p0 & w_hp6);
  assign w_x[7] = a[7] ^ (w_p0 & w_hp7);
  assign w_co   = w_p0 & w_gh;

  assign x  = w_x;
  assign co = w_co;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x  <= 8'h00;
      r_co <= 1'b0;
    end else begin
      r_x  <= w_x;
      r_co <= w_co;
    end
  end

  assign x_q  = r_x;
  assign co_q = r_co;

`ifdef S3_INC8_CHECK_EN
  logic [7:0] w_ref;
  logic       w_bad;
  logic       r_err;

  // Behavioural reference guards the structural carry network; any disagreement latches until reset.
  assign w_ref = a + 8'd1;
  assign w_bad = (w_x != w_ref) || (w_co != (a == 8'hFF));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_s3_inc8_unit.sv
// Scoreboard bench for s3_inc8_unit: stimulus pushes expected results, a monitor pops and compares.
module tb_s3_inc8_unit;

  typedef struct {
    logic [7:0] a;
    logic [7:0] x;
    logic       co;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] x;
  logic       co;
  logic [7:0] x_q;
  logic       co_q;
  logic       err;

  exp_t combQ[$];
  exp_t regQ[$];
  int   compareCount = 0;
  int   failCount    = 0;
  logic [7:0] fbReg;

  s3_inc8_unit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .x    (x),
    .co   (co),
    .x_q  (x_q),
    .co_q (co_q),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs shortly after the rising edge and records what the model predicts.
  task automatic applyStimulus(input logic [7:0] aVal, input logic rstVal);
    exp_t e;
    int   sum;
    @(posedge clk);
    #2;
    a   = aVal;
    rst = rstVal;
    sum = int'(aVal) + 1;
    e.a  = aVal;
    e.x  = 8'(sum % 256);
    e.co = (sum == 256);
    combQ.push_back(e);
    if (rstVal) begin
      e.x  = 8'h00;
      e.co = 1'b0;
    end
    regQ.push_back(e);
  endtask

  // Monitor: combinational results checked mid-cycle, registered results just after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (combQ.size() > 0) begin
        e = combQ.pop_front();
        checkOutput($sformatf("x(a=%0h)", e.a), {1'b0, x}, {1'b0, e.x});
        checkOutput($sformatf("co(a=%0h)", e.a), {8'h00, co}, {8'h00, e.co});
      end
      @(posedge clk);
      #1;
      if (regQ.size() > 0) begin
        e = regQ.pop_front();
        checkOutput($sformatf("x_q(a=%0h)", e.a), {1'b0, x_q}, {1'b0, e.x});
        checkOutput($sformatf("co_q(a=%0h)", e.a), {8'h00, co_q}, {8'h00, e.co});
        checkOutput("err", {8'h00, err}, 9'h000);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a   = 8'h00;

    for (int i = 0; i < 10; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h05, 1'b0);

    for (int i = 0; i < 256; i++) applyStimulus(8'(i), 1'b0);

    applyStimulus(8'h0F, 1'b0);
    applyStimulus(8'h7F, 1'b0);
    applyStimulus(8'hFF, 1'b0);

    // External feedback register loads x each cycle; its value is checked against a plain count.
    fbReg = 8'h00;
    for (int i = 0; i < 300; i++) begin
      checkOutput("fbSeq", {1'b0, fbReg}, 9'(i % 256));
      applyStimulus(fbReg, 1'b0);
      #1;
      fbReg = x;
    end
    checkOutput("fbFinal", {1'b0, fbReg}, 9'h02C);

    applyStimulus(8'h42, 1'b0);
    applyStimulus(8'h42, 1'b1);
    applyStimulus(8'h42, 1'b0);

    for (int i = 0; i < 100; i++) applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 15) == 0));

    repeat (3) @(posedge clk);
    #3;
    checkOutput("drain", 9'(combQ.size() + regQ.size()), 9'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
